// File: rtl/uart_cmd_line_parser.sv
// Parses "<letter>[spaces][digits]<CR|LF>" lines from the UART RX FIFO into a
// command letter plus an optional unsigned decimal argument.
module uart_cmd_line_parser #(
  parameter int MAX_DIGITS = 4,
  parameter int VAL_W      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_fifo_empty,
  input  logic [7:0]       i_fifo_rd_data,
  output logic             o_fifo_pop,
  output logic             o_cmd_valid,
  output logic [7:0]       o_cmd,
  output logic [VAL_W-1:0] o_value,
  output logic             o_has_value,
  output logic             o_err,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_EMIT, S_FLUSH} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [VAL_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_letter;
  logic             w_pop;
  logic             w_latch;
  logic             w_acc_en;
  logic             w_err;
  logic             w_is_letter;
  logic             w_is_digit;
  logic             w_is_sp;
  logic             w_is_term;
  logic             w_cnt_full;
  logic [VAL_W-1:0] w_acc_next;

  assign w_is_letter = ((i_fifo_rd_data >= 8'h41) && (i_fifo_rd_data <= 8'h5A)) ||
                       ((i_fifo_rd_data >= 8'h61) && (i_fifo_rd_data <= 8'h7A));
  assign w_is_digit  = (i_fifo_rd_data >= 8'h30) && (i_fifo_rd_data <= 8'h39);
  assign w_is_sp     = (i_fifo_rd_data == 8'h20);
  assign w_is_term   = (i_fifo_rd_data == 8'h0D) || (i_fifo_rd_data == 8'h0A);
  assign w_cnt_full  = (r_cnt == CNT_W'(MAX_DIGITS));

  // acc*10 + digit; truncating the sum to VAL_W gives the same low bits as
  // computing it wider first.
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) +
                      {{(VAL_W-4){1'b0}}, i_fifo_rd_data[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_acc_en = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          if (w_is_letter) begin
            w_latch = 1'b1;
            w_next  = S_ARG;
          end else if (!w_is_sp && !w_is_term) begin
            w_err  = 1'b1;
            w_next = S_FLUSH;
          end
        end
      end
      S_ARG: begin
        if (w_pop) begin
          if (w_is_digit) begin
            if (w_cnt_full) begin
              w_err  = 1'b1;
              w_next = S_FLUSH;
            end else begin
              w_acc_en = 1'b1;
            end
          end else if (w_is_sp) begin
            if (r_cnt != '0) begin
              w_err  = 1'b1;
              w_next = S_FLUSH;
            end
          end else if (w_is_term) begin
            w_next = S_EMIT;
          end else begin
            w_err  = 1'b1;
            w_next = S_FLUSH;
          end
        end
      end
      S_EMIT:  w_next = S_IDLE;
      S_FLUSH: if (w_pop && w_is_term) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop       = rst && !i_fifo_empty && (r_state != S_EMIT);
    o_fifo_pop  = w_pop;
    o_cmd_valid = (r_state == S_EMIT);
    o_busy      = (r_state != S_IDLE);
  end

  // Outputs only move when a well-formed line closes; errors leave them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_letter    <= 8'h00;
      o_cmd       <= 8'h00;
      o_value     <= '0;
      o_has_value <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_err <= w_err;
      if (w_latch) begin
        r_letter <= i_fifo_rd_data & 8'hDF;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (w_acc_en) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == S_ARG) && (w_next == S_EMIT)) begin
        o_cmd       <= r_letter;
        o_value     <= r_acc;
        o_has_value <= (r_cnt != '0);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_line_parser.sv
// Bench for uart_cmd_line_parser: a line-level model predicts, per consumed
// byte, the error/command event and busy level; outputs are checked every cycle.
module tb_uart_cmd_line_parser;
  localparam int MAX_DIGITS = 4;
  localparam int VAL_W      = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_fifo_empty = 1'b1;
  logic [7:0]       i_fifo_rd_data = 8'h00;
  logic             o_fifo_pop;
  logic             o_cmd_valid;
  logic [7:0]       o_cmd;
  logic [VAL_W-1:0] o_value;
  logic             o_has_value;
  logic             o_err;
  logic             o_busy;

  uart_cmd_line_parser #(.MAX_DIGITS(MAX_DIGITS), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst(rst), .i_fifo_empty(i_fifo_empty), .i_fifo_rd_data(i_fifo_rd_data),
    .o_fifo_pop(o_fifo_pop), .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_value(o_value),
    .o_has_value(o_has_value), .o_err(o_err), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  bit         hold_empty = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_pushed = 0;
  int         n_popped = 0;
  int         cnt_valid = 0, cnt_err = 0, cnt_pop = 0;

  // Per global byte index: 0 none, 1 error, 2 command completes.
  int         kind_a [0:511];
  bit         bsy_a  [0:511];
  logic [7:0] cmd_a  [0:511];
  int         val_a  [0:511];
  bit         has_a  [0:511];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exv, $time);
    end
  endtask

  function automatic bit is_d(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction
  function automatic bit is_l(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction
  function automatic bit is_t(input logic [7:0] c);
    return (c == 8'h0D) || (c == 8'h0A);
  endfunction

  task automatic mark(input int pos, input int k, input bit b);
    kind_a[n_pushed + pos] = k;
    bsy_a[n_pushed + pos]  = b;
  endtask

  // Bad byte at p: one error there, rest of the line swallowed until its terminator.
  task automatic fail_line(input string s, input int p, input int e);
    mark(p, 1, 1'b1);
    for (int j = p + 1; j < e; j++) mark(j, 0, 1'b1);
    if (e < s.len()) mark(e, 0, 1'b0);
  endtask

  task automatic model_line(input string s, input int a, input int e);
    int p, v, nd;
    logic [7:0] c, let_c;
    p = a;
    while (p < e && s[p] == 8'h20) begin mark(p, 0, 1'b0); p++; end
    if (p == e) begin
      if (e < s.len()) mark(e, 0, 1'b0);
      return;
    end
    c = s[p];
    if (!is_l(c)) begin fail_line(s, p, e); return; end
    let_c = c & 8'hDF;
    mark(p, 0, 1'b1);
    p++;
    while (p < e && s[p] == 8'h20) begin mark(p, 0, 1'b1); p++; end
    v = 0; nd = 0;
    while (p < e && is_d(s[p]) && nd < MAX_DIGITS) begin
      v = v * 10 + (s[p] - 8'h30);
      nd++;
      mark(p, 0, 1'b1);
      p++;
    end
    if (p == e) begin
      if (e < s.len()) begin
        mark(e, 2, 1'b1);
        cmd_a[n_pushed + e] = let_c;
        val_a[n_pushed + e] = v % (1 << VAL_W);
        has_a[n_pushed + e] = (nd != 0);
      end
      return;
    end
    fail_line(s, p, e);
  endtask

  task automatic push(input string s);
    int i, e;
    i = 0;
    while (i < s.len()) begin
      e = i;
      while (e < s.len() && !is_t(s[e])) e++;
      model_line(s, i, e);
      i = e + 1;
    end
    for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
    n_pushed += s.len();
  endtask

  // Cycle-by-cycle compare against the model, plus the FIFO that feeds the DUT.
  bit         prev_pop = 1'b0, prev_valid = 1'b0, popped;
  int         idx;
  bit         exp_err, exp_valid, exp_has, exp_busy;
  logic [7:0] exp_cmd;
  int         exp_val;
  initial begin
    exp_busy = 0; exp_cmd = 0; exp_val = 0; exp_has = 0;
    forever begin
      @(negedge clk);
      popped = 1'b0;
      idx = 0;
      if (prev_pop) begin
        if (q.size() > 0) void'(q.pop_front());
        idx = n_popped;
        n_popped++;
        popped = 1'b1;
        cnt_pop++;
      end
      if (!rst) begin
        exp_err = 0; exp_valid = 0; exp_cmd = 0; exp_val = 0; exp_has = 0; exp_busy = 0;
      end else begin
        exp_err   = popped && (kind_a[idx] == 1);
        exp_valid = popped && (kind_a[idx] == 2);
        if (exp_valid) begin
          exp_cmd = cmd_a[idx]; exp_val = val_a[idx]; exp_has = has_a[idx];
        end
        if (popped) exp_busy = bsy_a[idx];
        else if (prev_valid) exp_busy = 1'b0;
      end
      check("err", o_err, exp_err);
      check("cmd_valid", o_cmd_valid, exp_valid);
      check("cmd", o_cmd, exp_cmd);
      check("value", o_value, exp_val);
      check("has_value", o_has_value, exp_has);
      check("busy", o_busy, exp_busy);
      if (o_cmd_valid) cnt_valid++;
      if (o_err) cnt_err++;
      prev_valid = exp_valid;
      i_fifo_empty   = hold_empty || (q.size() == 0);
      i_fifo_rd_data = (q.size() > 0) ? q[0] : 8'h00;
      #1;
      check("fifo_pop", o_fifo_pop, rst && !i_fifo_empty && !exp_valid);
      prev_pop = o_fifo_pop;
    end
  end

  task automatic drain(input bit need_idle);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (q.size() == 0 && (!need_idle || !o_busy)) break;
    end
    if (k == 400) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d bytes left, expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic clr_cnt();
    cnt_valid = 0; cnt_err = 0; cnt_pop = 0;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_value", o_value, 0);
    check("rst_cmd", o_cmd, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    clr_cnt(); push("S123\n"); drain(1'b1);
    check("s_valid_cnt", cnt_valid, 1);
    check("s_err_cnt", cnt_err, 0);
    check("s_pops", cnt_pop, 5);
    check("s_cmd", o_cmd, 8'h53);
    check("s_value", o_value, 123);
    check("s_has", o_has_value, 1);

    clr_cnt(); push("r\r\n"); drain(1'b1);
    check("r_valid_cnt", cnt_valid, 1);
    check("r_err_cnt", cnt_err, 0);
    check("r_cmd", o_cmd, 8'h52);
    check("r_value", o_value, 0);
    check("r_has", o_has_value, 0);

    clr_cnt(); push("T12345\n"); push("A 0007\n"); drain(1'b1);
    check("ta_valid_cnt", cnt_valid, 1);
    check("ta_err_cnt", cnt_err, 1);
    check("ta_cmd", o_cmd, 8'h41);
    check("ta_value", o_value, 7);
    check("ta_has", o_has_value, 1);

    clr_cnt(); push("X1 2\n"); push("?\n"); push("B9\n"); drain(1'b1);
    check("xb_valid_cnt", cnt_valid, 1);
    check("xb_err_cnt", cnt_err, 2);
    check("xb_cmd", o_cmd, 8'h42);
    check("xb_value", o_value, 9);

    clr_cnt(); hold_empty = 1'b1; push("D42\n");
    for (int b = 0; b < 4; b++) begin
      repeat (10) @(posedge clk);
      #2;
      hold_empty = 1'b0;
      @(posedge clk);
      #2;
      hold_empty = 1'b1;
      if (b == 1) begin
        repeat (4) @(posedge clk);
        #2;
        check("d_gap_busy", o_busy, 1);
        check("d_gap_pop", o_fifo_pop, 0);
      end
    end
    repeat (10) @(posedge clk);
    #2;
    hold_empty = 1'b0;
    drain(1'b1);
    check("d_valid_cnt", cnt_valid, 1);
    check("d_pops", cnt_pop, 4);
    check("d_value", o_value, 42);
    check("d_cmd", o_cmd, 8'h44);

    clr_cnt(); push("W5"); drain(1'b0);
    check("w_busy", o_busy, 1);
    rst = 1'b0;
    push("7\nC1\n");
    repeat (3) @(posedge clk);
    #2;
    check("w_rst_pop", o_fifo_pop, 0);
    check("w_rst_busy", o_busy, 0);
    check("w_rst_value", o_value, 0);
    rst = 1'b1;
    drain(1'b1);
    check("c_valid_cnt", cnt_valid, 1);
    check("c_err_cnt", cnt_err, 1);
    check("c_cmd", o_cmd, 8'h43);
    check("c_value", o_value, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
